ahb_modport: RTL and testbench

AHB-Lite slave endpoint with an internal byte-addressable memory, attached to the slave side of the shared AHB bus interface. It samples address/control on the canonical AHB pipeline and drives HREADYOUT, HRESP and HRDATA during the data phase. It supports programmable wait states and a two-cycle ERROR response. It is the reference target for master-side and monitor-side verification of the AHB VIP.

---
 rtl/ahb_modport.sv | 153 +++++++++++++++
 tb/tb_ahb_modport.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_modport.sv
// AHB-Lite slave endpoint backed by a byte-addressable internal memory,
// with programmable wait states and a two-cycle ERROR response.
module ahb_modport #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_STATES = 0,
  parameter int HRESP_W     = 2
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               HSEL,
  input  logic [ADDR_W-1:0]  HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  logic [3:0]         HPROT,
  input  logic               HMASTLOCK,
  input  logic [3:0]         HMASTER,
  input  logic [DATA_W-1:0]  HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic [HRESP_W-1:0] HRESP,
  output logic [DATA_W-1:0]  HRDATA
);
  localparam int LANES     = DATA_W / 8;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int MEM_AW    = $clog2(MEM_BYTES);
  localparam int CNT_W     = 4;
  localparam logic [HRESP_W-1:0] RESP_OKAY  = HRESP_W'(0);
  localparam logic [HRESP_W-1:0] RESP_ERROR = HRESP_W'(1);

  // S_DATA is the single ready-high OKAY cycle that completes a transfer.
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t              state;
  logic [CNT_W-1:0]    wait_cnt;
  logic [MEM_AW-1:0]   ph_addr;
  logic                ph_write;
  logic [2:0]          ph_size;
  logic                ready_q;
  logic [HRESP_W-1:0]  resp_q;
  logic [7:0]          mem [MEM_BYTES];

  logic                can_start;
  logic                accept;
  logic                xfer_err;
  logic [ADDR_W-1:0]   align_mask;
  logic [LANES-1:0]    lane_en;
  logic [MEM_AW-LANE_BITS-1:0] word_idx;
  int                  lane_lo;
  int                  lane_n;
  logic                unused;

  assign unused    = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK, HMASTER};
  assign can_start = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept    = can_start && HSEL && HREADY && HTRANS[1];
  assign word_idx  = ph_addr[MEM_AW-1:LANE_BITS];
  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;

  always_comb begin
    align_mask = (ADDR_W'(1) << HSIZE) - ADDR_W'(1);
    xfer_err   = (int'(HSIZE) > LANE_BITS) || ((HADDR & align_mask) != '0) ||
                 (HADDR >= ADDR_W'(MEM_BYTES));
  end

  always_comb begin
    lane_lo = int'(ph_addr[LANE_BITS-1:0]);
    lane_n  = int'(32'd1 << ph_size);
    lane_en = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_en[i] = (i >= lane_lo) && (i < lane_lo + lane_n);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      ph_addr  <= '0;
      ph_write <= 1'b0;
      ph_size  <= 3'd0;
      ready_q  <= 1'b1;
      resp_q   <= RESP_OKAY;
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state   <= S_DATA;
            ready_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_ERR1: begin
          state   <= S_ERR2;
          ready_q <= 1'b1;
          resp_q  <= RESP_ERROR;
        end
        default: begin
          // IDLE, DATA and ERR2 all end a data phase, so a new transfer may start.
          if (accept) begin
            ph_addr  <= HADDR[MEM_AW-1:0];
            ph_write <= HWRITE;
            ph_size  <= HSIZE;
            if (xfer_err) begin
              state   <= S_ERR1;
              ready_q <= 1'b0;
              resp_q  <= RESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state    <= S_WAIT;
              wait_cnt <= CNT_W'(WAIT_STATES - 1);
              ready_q  <= 1'b0;
              resp_q   <= RESP_OKAY;
            end else begin
              state   <= S_DATA;
              ready_q <= 1'b1;
              resp_q  <= RESP_OKAY;
            end
          end else begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            resp_q  <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  // Memory is deliberately not reset; a reset edge discards the pending write.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (state == S_DATA) && ph_write) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_en[i]) begin
          mem[{word_idx, LANE_BITS'(i)}] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if ((state == S_DATA) && !ph_write) begin
      for (int i = 0; i < LANES; i++) begin
        HRDATA[8*i +: 8] = mem[{word_idx, LANE_BITS'(i)}];
      end
    end else begin
      HRDATA = '0;
    end
  end
endmodule

// File: tb/tb_ahb_modport.sv
// Self-checking bench for ahb_modport: a zero-wait and a two-wait instance,
// checked every cycle against a transaction-level reference model.
module tb_ahb_modport;
  localparam int MEMB = 1024;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        hreset;
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [31:0] hwdata [2];
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [3:0]  hmaster;
  logic        rdy0, rdy1;
  logic [1:0]  resp0, resp1;
  logic [31:0] rd0, rd1;

  ahb_modport #(.WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst), .HPROT(hprot),
    .HMASTLOCK(hmastlock), .HMASTER(hmaster), .HWDATA(hwdata[0]), .HREADY(rdy0),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0));

  ahb_modport #(.WAIT_STATES(2)) dut2 (
    .HCLK(HCLK), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst), .HPROT(hprot),
    .HMASTLOCK(hmastlock), .HMASTER(hmaster), .HWDATA(hwdata[1]), .HREADY(rdy1),
    .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rd1));

  // One expected bus cycle of the reference model.
  typedef struct packed {
    logic        ready;
    logic [1:0]  resp;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
  } ent_t;

  ent_t        q    [2][$];
  ent_t        cur  [2];
  logic [7:0]  mmem [2][MEMB];
  logic        exp_ready [2];
  logic [1:0]  exp_resp  [2];
  logic [31:0] exp_rdata [2];
  logic        chk_en = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;

  function automatic ent_t mk(logic r, logic [1:0] rs, logic rd, logic wr,
                              logic [31:0] a, logic [2:0] s);
    ent_t e;
    e.ready = r; e.resp = rs; e.rd = rd; e.wr = wr; e.addr = a; e.size = s;
    return e;
  endfunction

  function automatic int ws(int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic logic get_rdy(int k);
    return (k == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic [1:0] get_resp(int k);
    return (k == 0) ? resp0 : resp1;
  endfunction

  function automatic logic [31:0] get_rdata(int k);
    return (k == 0) ? rd0 : rd1;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference model: advance one clock edge for instance k.
  task automatic model_edge(int k);
    int nb;
    int base;
    if (hreset) begin
      q[k].delete();
      cur[k] = mk(1'b1, 2'd0, 1'b0, 1'b0, 32'd0, 3'd0);
    end else begin
      if (cur[k].wr && cur[k].ready && cur[k].resp == 2'd0) begin
        for (int b = 0; b < (1 << cur[k].size); b++) begin
          mmem[k][cur[k].addr + b] = hwdata[k][8*((cur[k].addr % 4) + b) +: 8];
        end
      end
      if (hsel[k] && htrans[k][1] && cur[k].ready) begin
        nb = 1 << hsize[k];
        if (nb > 4 || (haddr[k] % nb) != 0 || haddr[k] >= MEMB) begin
          q[k].push_back(mk(1'b0, 2'd1, 1'b0, 1'b0, haddr[k], hsize[k]));
          q[k].push_back(mk(1'b1, 2'd1, 1'b0, 1'b0, haddr[k], hsize[k]));
        end else begin
          repeat (ws(k)) q[k].push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, haddr[k], hsize[k]));
          q[k].push_back(mk(1'b1, 2'd0, !hwrite[k], hwrite[k], haddr[k], hsize[k]));
        end
      end
      cur[k] = (q[k].size() > 0) ? q[k].pop_front() : mk(1'b1, 2'd0, 1'b0, 1'b0, 32'd0, 3'd0);
    end
    exp_ready[k] = cur[k].ready;
    exp_resp[k]  = cur[k].resp;
    exp_rdata[k] = 32'd0;
    if (cur[k].rd && cur[k].ready && cur[k].resp == 2'd0) begin
      base = int'(cur[k].addr) & ~3;
      exp_rdata[k] = {mmem[k][base+3], mmem[k][base+2], mmem[k][base+1], mmem[k][base]};
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic idle_bus(int k);
    hsel[k] = 1'b0;
    htrans[k] = 2'd0;
  endtask

  task automatic addr_phase(int k, logic wr, logic [2:0] sz, logic [31:0] a);
    hsel[k] = 1'b1; htrans[k] = 2'd2; hwrite[k] = wr; hsize[k] = sz; haddr[k] = a;
  endtask

  task automatic xfer(int k, logic wr, logic [2:0] sz, logic [31:0] a, logic [31:0] wd,
                      output logic [31:0] rd, output logic [1:0] rs);
    int n;
    addr_phase(k, wr, sz, a);
    tick();
    idle_bus(k);
    hwdata[k] = wd;
    n = 0;
    while (get_rdy(k) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'(get_rdy(k)), 32'd1);
    rd = get_rdata(k);
    rs = get_resp(k);
    tick();
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge HCLK) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("hreadyout[%0d]", k), 32'(get_rdy(k)), 32'(exp_ready[k]));
        check($sformatf("hresp[%0d]", k), 32'(get_resp(k)), 32'(exp_resp[k]));
        check($sformatf("hrdata[%0d]", k), get_rdata(k), exp_rdata[k]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    int r;
    hreset = 1'b1;
    hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0; hmaster = 4'd0;
    for (int k = 0; k < 2; k++) begin
      idle_bus(k);
      haddr[k] = 32'd0; hwrite[k] = 1'b0; hsize[k] = 3'd0; hwdata[k] = 32'd0;
      for (int a = 0; a < MEMB; a++) mmem[k][a] = 8'd0;
    end
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_ready0", 32'(rdy0), 32'd1);
    check("rst_resp0", 32'(resp0), 32'd0);
    check("rst_rdata0", rd0, 32'd0);
    check("rst_ready2", 32'(rdy1), 32'd1);
    hreset = 1'b0;

    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 128; a += 4) xfer(k, 1'b1, 3'd2, 32'(a), 32'd0, rd, rs);

    // Zero-wait word write then read.
    xfer(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, rs);
    addr_phase(0, 1'b0, 3'd2, 32'h10);
    tick();
    idle_bus(0);
    check("zw_ready", 32'(rdy0), 32'd1);
    check("word_rd", rd0, 32'hDEADBEEF);
    check("word_resp", 32'(resp0), 32'd0);
    tick();

    // Byte into lane 1, halfword into lanes 2-3.
    xfer(0, 1'b1, 3'd0, 32'h21, 32'h0000AA00, rd, rs);
    xfer(0, 1'b1, 3'd1, 32'h22, 32'h12340000, rd, rs);
    xfer(0, 1'b0, 3'd2, 32'h20, 32'd0, rd, rs);
    check("subword_rd", rd, 32'h1234AA00);

    // Write data phase overlaps the read address phase.
    addr_phase(0, 1'b1, 3'd2, 32'h40);
    tick();
    addr_phase(0, 1'b0, 3'd2, 32'h40);
    hwdata[0] = 32'h5;
    tick();
    idle_bus(0);
    check("b2b_rd", rd0, 32'h5);
    tick();

    // Out-of-range read: two ERROR cycles.
    addr_phase(0, 1'b0, 3'd2, 32'(MEMB));
    tick();
    idle_bus(0);
    check("err1_ready", 32'(rdy0), 32'd0);
    check("err1_resp", 32'(resp0), 32'd1);
    tick();
    check("err2_ready", 32'(rdy0), 32'd1);
    check("err2_resp", 32'(resp0), 32'd1);
    tick();
    check("post_err_resp", 32'(resp0), 32'd0);

    // Misaligned word write must not touch memory.
    xfer(0, 1'b1, 3'd2, 32'h2, 32'hFFFFFFFF, rd, rs);
    check("misalign_resp", 32'(rs), 32'd1);
    xfer(0, 1'b0, 3'd2, 32'h0, 32'd0, rd, rs);
    check("misalign_mem", rd, 32'd0);

    // Two wait states on a read.
    xfer(1, 1'b1, 3'd2, 32'h50, 32'h11223344, rd, rs);
    addr_phase(1, 1'b0, 3'd2, 32'h50);
    tick();
    idle_bus(1);
    check("ws_cyc1", 32'(rdy1), 32'd0);
    tick();
    check("ws_cyc2", 32'(rdy1), 32'd0);
    tick();
    check("ws_done", 32'(rdy1), 32'd1);
    check("ws_rd", rd1, 32'h11223344);
    tick();

    // Reset during the wait phase of a write discards it.
    addr_phase(1, 1'b1, 3'd2, 32'h30);
    tick();
    idle_bus(1);
    hwdata[1] = 32'hCAFEF00D;
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    check("midrst_ready", 32'(rdy1), 32'd1);
    xfer(1, 1'b0, 3'd2, 32'h30, 32'd0, rd, rs);
    check("midrst_mem", rd, 32'd0);

    // Randomized traffic, one instance at a time.
    for (int k = 0; k < 2; k++) begin
      repeat (400) begin
        hsel[k]   = ($urandom_range(0, 7) != 0);
        htrans[k] = 2'($urandom_range(0, 3));
        hwrite[k] = 1'($urandom_range(0, 1));
        hsize[k]  = 3'($urandom_range(0, 3));
        r = int'($urandom_range(0, 15));
        if (r == 0) haddr[k] = 32'(MEMB + $urandom_range(0, 64));
        else if (r == 1) haddr[k] = $urandom;
        else haddr[k] = 32'($urandom_range(0, 127));
        hwdata[k] = $urandom;
        hburst    = 3'($urandom_range(0, 7));
        hprot     = 4'($urandom_range(0, 15));
        tick();
      end
      idle_bus(k);
      repeat (4) tick();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
